pp_sched: RTL and testbench
===========================

PP_SCHED -- requirements
Module: pp_sched

Interface
REQ-001 CMD_SIZE_LOG2, 3, command width CW = 2**CMD_SIZE_LOG2 bits.
REQ-002 DATA_W, 32, operand and result width.
REQ-003 DEPTH, 4, command queue entries; power of 2, >= 2.
REQ-004 TIMEOUT, 255, max WAIT cycles allowed for engine valid; >= 2.
REQ-005 clk  input  1  single clock; all state updates on posedge clk.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 s_valid  input  1  host offers a command.
REQ-008 s_ready  output  1  queue can accept a command.
REQ-009 s_cmd  input  CW  command opcode.
REQ-010 s_in1  input  DATA_W  operand 1.
REQ-011 s_in2  input  DATA_W  operand 2.
REQ-012 m_valid  output  1  result available to host.
REQ-013 m_ready  input  1  host accepts result.
REQ-014 m_data  output  DATA_W  result value.
REQ-015 m_err  output  1  result is a timeout error.
REQ-016 eng_reset  output  1  reset to compute engine.
REQ-017 eng_enable  output  1  one-cycle start pulse to engine.
REQ-018 eng_cmd  output  CW  opcode to engine.
REQ-019 eng_in1  output  DATA_W  operand 1 to engine.
REQ-020 eng_in2  output  DATA_W  operand 2 to engine.
REQ-021 eng_valid  input  1  engine result valid.
REQ-022 eng_out  input  DATA_W  engine result.
REQ-023 busy  output  1  queue non-empty or FSM not IDLE.

Function
REQ-024 Push occurs when s_valid && s_ready; entries stored {cmd,in1,in2}, strict FIFO order.
REQ-025 s_ready = (count < DEPTH) from registered count; full queue refuses push even if a pop occurs the same cycle.
REQ-026 Simultaneous push and pop with 0 < count < DEPTH leaves count unchanged; pointers wrap modulo DEPTH.
REQ-027 FSM states IDLE, ISSUE, WAIT, RESP.
REQ-028 IDLE: if count != 0, pop head into eng_cmd/eng_in1/eng_in2 registers, go ISSUE; else stay.
REQ-029 ISSUE: eng_enable = 1 for exactly this cycle, timer cleared, go WAIT.
REQ-030 WAIT: eng_enable = 0, operands held stable; eng_valid = 1 -> m_data <= eng_out, m_err <= 0, go RESP.
REQ-031 WAIT: no eng_valid -> timer increments; on the TIMEOUT-th WAIT cycle without eng_valid -> m_data <= 0, m_err <= 1, eng_reset pulsed 1 cycle, go RESP.
REQ-032 eng_valid coincident with the timeout cycle: valid wins, no error, no eng_reset pulse.
REQ-033 eng_valid outside WAIT is ignored.
REQ-034 RESP: m_valid = 1, m_data/m_err held; on m_ready go IDLE, m_valid deasserts next cycle.
REQ-035 Latency: push into empty idle block in cycle N -> eng_enable in cycle N+2; eng_valid in cycle K -> m_valid in cycle K+1.
REQ-036 Queue keeps accepting pushes while FSM is in ISSUE/WAIT/RESP.
REQ-037 busy = (state != IDLE) || (count != 0), combinational.

Reset
REQ-038 While reset = 1: state IDLE, count/pointers/timer 0, m_valid/m_err/m_data/eng_enable/eng_cmd/eng_in1/eng_in2 = 0, s_ready = 0, eng_reset = 1.
REQ-039 Reset mid-operation discards queued and in-flight commands; no m_valid produced for them.
REQ-040 First cycle after reset deasserts: s_ready = 1, eng_reset = 0.

Verification
REQ-041 Push cmd=0x03,in1=5,in2=7 at cycle N; engine returns eng_out=12 two cycles after enable -> eng_enable at N+2, m_valid with m_data=12, m_err=0.
REQ-042 Push 5 commands back-to-back with engine stalled -> 4 accepted, s_ready=0 on 5th; results return in push order.
REQ-043 Engine never asserts eng_valid -> after 255 WAIT cycles m_valid=1, m_err=1, m_data=0, one-cycle eng_reset pulse.
REQ-044 eng_valid on exactly the 255th WAIT cycle with eng_out=0xA5 -> m_data=0xA5, m_err=0, no eng_reset pulse.
REQ-045 Hold m_ready=0 for 10 cycles in RESP -> m_valid/m_data stable, no new eng_enable until acceptance.
REQ-046 Assert reset during WAIT with 2 queued -> busy=0, count=0, no m_valid after reset release.

Source files
------------

// File: rtl/pp_sched.sv
// pp_sched: FIFO of {cmd,in1,in2} commands issued one at a time to a compute engine.
// A watchdog on the engine's response turns a hung engine into an error result.
module pp_sched #(
    parameter int CMD_SIZE_LOG2 = 3,
    parameter int DATA_W        = 32,
    parameter int DEPTH         = 4,
    parameter int TIMEOUT       = 255
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [(2**CMD_SIZE_LOG2)-1:0] s_cmd,
    input  logic [DATA_W-1:0]             s_in1,
    input  logic [DATA_W-1:0]             s_in2,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [DATA_W-1:0]             m_data,
    output logic                          m_err,
    output logic                          eng_reset,
    output logic                          eng_enable,
    output logic [(2**CMD_SIZE_LOG2)-1:0] eng_cmd,
    output logic [DATA_W-1:0]             eng_in1,
    output logic [DATA_W-1:0]             eng_in2,
    input  logic                          eng_valid,
    input  logic [DATA_W-1:0]             eng_out,
    output logic                          busy
);
    localparam int CW    = 2**CMD_SIZE_LOG2;
    localparam int EW    = CW + 2*DATA_W;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [TMR_W-1:0] LAST_TICK = TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state_reg, state_next;
    logic [EW-1:0]     mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [TMR_W-1:0]  timer_reg;
    logic              eng_rst_pulse_reg;
    logic              m_err_reg;
    logic [DATA_W-1:0] m_data_reg;
    logic [CW-1:0]     eng_cmd_reg;
    logic [DATA_W-1:0] eng_in1_reg, eng_in2_reg;
    logic              push, pop, timeout_hit;

    // Readiness comes from the registered count only, so a full queue never
    // accepts on the strength of a same-cycle pop.
    assign s_ready = !reset && (count_reg < FULL_CNT);
    assign push    = s_valid && s_ready;
    assign pop     = (state_reg == IDLE) && (count_reg != '0);

    assign eng_enable = !reset && (state_reg == ISSUE);
    assign m_valid    = !reset && (state_reg == RESP);
    assign eng_reset  = reset || eng_rst_pulse_reg;
    assign busy       = (state_reg != IDLE) || (count_reg != '0);
    assign m_data     = m_data_reg;
    assign m_err      = m_err_reg;
    assign eng_cmd    = eng_cmd_reg;
    assign eng_in1    = eng_in1_reg;
    assign eng_in2    = eng_in2_reg;

    always_ff @(posedge clk) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next  = state_reg;
        timeout_hit = 1'b0;
        case (state_reg)
            IDLE:  if (count_reg != '0) state_next = ISSUE;
            ISSUE: state_next = WAIT;
            // A response on the final watchdog cycle still counts as success.
            WAIT: begin
                if (eng_valid) begin
                    state_next = RESP;
                end else if (timer_reg == LAST_TICK) begin
                    state_next  = RESP;
                    timeout_hit = 1'b1;
                end
            end
            RESP:  if (m_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg] <= {s_cmd, s_in1, s_in2};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg        <= '0;
            rd_ptr_reg        <= '0;
            count_reg         <= '0;
            timer_reg         <= '0;
            eng_rst_pulse_reg <= 1'b0;
            m_data_reg        <= '0;
            m_err_reg         <= 1'b0;
            eng_cmd_reg       <= '0;
            eng_in1_reg       <= '0;
            eng_in2_reg       <= '0;
        end else begin
            eng_rst_pulse_reg <= timeout_hit;
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
                {eng_cmd_reg, eng_in1_reg, eng_in2_reg} <= mem[rd_ptr_reg];
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
            case (state_reg)
                ISSUE: timer_reg <= '0;
                WAIT: begin
                    if (eng_valid) begin
                        m_data_reg <= eng_out;
                        m_err_reg  <= 1'b0;
                    end else if (timeout_hit) begin
                        m_data_reg <= '0;
                        m_err_reg  <= 1'b1;
                    end else begin
                        timer_reg <= timer_reg + TMR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_pp_sched.sv
// Directed plus randomized bench for pp_sched; engine behaviour is modelled here and
// results are compared against a queue-based model of command/response ordering.
module tb_pp_sched;
    localparam int CSL = 3;
    localparam int CW  = 8;
    localparam int DW  = 32;
    localparam int DEP = 4;
    localparam int TO  = 255;

    logic          clk = 1'b0;
    logic          reset, s_valid, s_ready, m_valid, m_ready, m_err;
    logic          eng_reset, eng_enable, eng_valid, busy;
    logic [CW-1:0] s_cmd, eng_cmd;
    logic [DW-1:0] s_in1, s_in2, m_data, eng_in1, eng_in2, eng_out;

    typedef logic [CW+2*DW-1:0] ent_t;
    ent_t          exp_q[$];
    logic [DW:0]   res_q[$];
    ent_t          e;
    logic          pending, ok;
    int            wait_left;
    int            checks = 0;
    int            errors = 0;

    pp_sched #(.CMD_SIZE_LOG2(CSL), .DATA_W(DW), .DEPTH(DEP), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_cmd(s_cmd),
        .s_in1(s_in1), .s_in2(s_in2), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_err(m_err), .eng_reset(eng_reset), .eng_enable(eng_enable),
        .eng_cmd(eng_cmd), .eng_in1(eng_in1), .eng_in2(eng_in2), .eng_valid(eng_valid),
        .eng_out(eng_out), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout observed=hang required=finish");
        $fatal(1, "simulation time limit");
    end

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [CW-1:0] c, input logic [DW-1:0] a, input logic [DW-1:0] b);
        chk("push_ready", 80'(s_ready), 80'(1));
        s_valid = 1'b1; s_cmd = c; s_in1 = a; s_in2 = b;
        tick();
        s_valid = 1'b0;
    endtask

    task automatic wait_enable(input string tag);
        for (int i = 0; i < 20 && eng_enable !== 1'b1; i++) tick();
        chk(tag, 80'(eng_enable), 80'(1));
    endtask

    // Called in the ISSUE cycle; engine answers in the first WAIT cycle.
    task automatic respond(input logic [DW-1:0] d);
        tick();
        eng_valid = 1'b1; eng_out = d;
        tick();
        eng_valid = 1'b0;
        chk("resp_valid", 80'(m_valid), 80'(1));
        chk("resp_data", 80'(m_data), 80'(d));
        chk("resp_err", 80'(m_err), 80'(0));
        $display("txn result data=%0h err=%0d", m_data, m_err);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk("resp_drop", 80'(m_valid), 80'(0));
    endtask

    initial begin
        reset = 1'b1; s_valid = 1'b0; s_cmd = '0; s_in1 = '0; s_in2 = '0;
        m_ready = 1'b0; eng_valid = 1'b0; eng_out = '0; pending = 1'b0; wait_left = 0;

        // Reset state
        tick(); tick();
        chk("rst_s_ready", 80'(s_ready), 80'(0));
        chk("rst_eng_reset", 80'(eng_reset), 80'(1));
        chk("rst_m_valid", 80'(m_valid), 80'(0));
        chk("rst_eng_enable", 80'(eng_enable), 80'(0));
        chk("rst_busy", 80'(busy), 80'(0));
        chk("rst_m_data", 80'({m_err, m_data}), 80'(0));
        reset = 1'b0;
        tick();
        chk("post_rst_s_ready", 80'(s_ready), 80'(1));
        chk("post_rst_eng_reset", 80'(eng_reset), 80'(0));

        // Basic latency: push in cycle N, enable in N+2, result one cycle after eng_valid
        push(8'h03, 32'd5, 32'd7);
        chk("lat_n1_enable", 80'(eng_enable), 80'(0));
        tick();
        chk("lat_n2_enable", 80'(eng_enable), 80'(1));
        chk("lat_operands", 80'({eng_cmd, eng_in1, eng_in2}), 80'({8'h03, 32'd5, 32'd7}));
        tick();
        chk("lat_n3_enable", 80'(eng_enable), 80'(0));
        tick();
        chk("lat_n4_m_valid", 80'(m_valid), 80'(0));
        eng_valid = 1'b1; eng_out = 32'd12;
        tick();
        eng_valid = 1'b0;
        chk("lat_m_valid", 80'(m_valid), 80'(1));
        chk("lat_m_data", 80'(m_data), 80'(12));
        chk("lat_m_err", 80'(m_err), 80'(0));
        $display("txn result data=%0h err=%0d", m_data, m_err);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk("lat_m_valid_drop", 80'(m_valid), 80'(0));
        chk("lat_busy_idle", 80'(busy), 80'(0));

        // Engine stalled on one command: a five-deep burst fills the queue at four
        push(8'h10, 32'h1, 32'h2);
        wait_enable("burst_first_enable");
        for (int k = 0; k < 5; k++) begin
            s_valid = 1'b1; s_cmd = 8'(8'h60 + k); s_in1 = 32'(k * 3); s_in2 = 32'(~k);
            chk("burst_s_ready", 80'(s_ready), 80'(k < DEP));
            if (s_ready) exp_q.push_back({s_cmd, s_in1, s_in2});
            tick();
        end
        s_valid = 1'b0;
        respond(32'h100);
        for (int k = 0; k < DEP; k++) begin
            wait_enable("burst_enable");
            e = exp_q.pop_front();
            chk("burst_order", 80'({eng_cmd, eng_in1, eng_in2}), 80'(e));
            respond(32'(32'h200 + k));
        end
        chk("burst_busy_idle", 80'(busy), 80'(0));

        // Engine never answers: watchdog fires on the TO-th WAIT cycle
        push(8'h20, 32'h3, 32'h4);
        wait_enable("to_enable");
        for (int i = 1; i < TO; i++) tick();
        chk("to_early_m_valid", 80'(m_valid), 80'(0));
        tick();
        chk("to_last_m_valid", 80'(m_valid), 80'(0));
        chk("to_last_eng_reset", 80'(eng_reset), 80'(0));
        tick();
        chk("to_m_valid", 80'(m_valid), 80'(1));
        chk("to_m_err", 80'(m_err), 80'(1));
        chk("to_m_data", 80'(m_data), 80'(0));
        chk("to_eng_reset_pulse", 80'(eng_reset), 80'(1));
        $display("txn result data=%0h err=%0d", m_data, m_err);
        tick();
        chk("to_eng_reset_end", 80'(eng_reset), 80'(0));
        chk("to_m_valid_hold", 80'(m_valid), 80'(1));
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk("to_m_valid_drop", 80'(m_valid), 80'(0));

        // eng_valid on exactly the last watchdog cycle wins; a push lands mid-WAIT
        push(8'h30, 32'h5, 32'h6);
        wait_enable("edge_enable");
        for (int i = 1; i < TO; i++) begin
            s_valid = (i == 10); s_cmd = 8'h40; s_in1 = 32'h11; s_in2 = 32'h22;
            tick();
        end
        s_valid = 1'b0;
        tick();
        chk("edge_pre_m_valid", 80'(m_valid), 80'(0));
        eng_valid = 1'b1; eng_out = 32'hA5;
        tick();
        eng_valid = 1'b0;
        chk("edge_m_valid", 80'(m_valid), 80'(1));
        chk("edge_m_data", 80'(m_data), 80'(32'hA5));
        chk("edge_m_err", 80'(m_err), 80'(0));
        chk("edge_no_eng_reset", 80'(eng_reset), 80'(0));
        $display("txn result data=%0h err=%0d", m_data, m_err);

        // Back-pressure in RESP with a command waiting behind it
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_m_valid", 80'(m_valid), 80'(1));
            chk("hold_m_data", 80'({m_err, m_data}), 80'(32'hA5));
            chk("hold_no_enable", 80'(eng_enable), 80'(0));
            chk("hold_no_eng_reset", 80'(eng_reset), 80'(0));
        end
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk("hold_m_valid_drop", 80'(m_valid), 80'(0));
        wait_enable("hold_next_enable");
        chk("hold_next_cmd", 80'({eng_cmd, eng_in1, eng_in2}), 80'({8'h40, 32'h11, 32'h22}));
        respond(32'h77);

        // Reset during WAIT with two queued commands discards everything
        push(8'h50, 32'h1, 32'h1);
        wait_enable("mid_rst_enable");
        s_valid = 1'b1; s_cmd = 8'h51;
        tick();
        s_cmd = 8'h52;
        tick();
        s_valid = 1'b0;
        chk("mid_rst_busy_before", 80'(busy), 80'(1));
        reset = 1'b1;
        tick();
        chk("mid_rst_eng_reset", 80'(eng_reset), 80'(1));
        chk("mid_rst_s_ready", 80'(s_ready), 80'(0));
        chk("mid_rst_busy", 80'(busy), 80'(0));
        chk("mid_rst_eng_cmd", 80'({eng_cmd, eng_in1, eng_in2}), 80'(0));
        reset = 1'b0;
        tick();
        chk("mid_rst_release_ready", 80'(s_ready), 80'(1));
        chk("mid_rst_release_eng_reset", 80'(eng_reset), 80'(0));
        m_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            eng_valid = i[0]; eng_out = 32'h5A;
            tick();
            chk("mid_rst_no_m_valid", 80'(m_valid), 80'(0));
            chk("mid_rst_no_enable", 80'(eng_enable), 80'(0));
            chk("mid_rst_idle", 80'(busy), 80'(0));
        end
        eng_valid = 1'b0; m_ready = 1'b0;

        // Randomized traffic: FIFO order, results, busy, spurious eng_valid
        exp_q.delete(); res_q.delete(); pending = 1'b0;
        for (int t = 0; t < 700; t++) begin
            chk("rnd_busy", 80'(busy), 80'(exp_q.size() != 0 || pending || res_q.size() != 0));
            if (eng_enable) begin
                if (exp_q.size() == 0) begin
                    chk("rnd_unexpected_enable", 80'(eng_enable), 80'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("rnd_operands", 80'({eng_cmd, eng_in1, eng_in2}), 80'(e));
                end
                pending = 1'b1;
                wait_left = $urandom_range(1, 6);
            end
            if (m_valid) begin
                if (res_q.size() == 0) chk("rnd_unexpected_m_valid", 80'(m_valid), 80'(0));
                else chk("rnd_result", 80'({m_err, m_data}), 80'(res_q[0]));
            end
            eng_valid = 1'b0; eng_out = $urandom;
            if (pending && !eng_enable) begin
                wait_left--;
                if (wait_left == 0) begin
                    eng_valid = 1'b1;
                    res_q.push_back({1'b0, eng_out});
                    pending = 1'b0;
                end
            end else if (!pending && !eng_enable) begin
                eng_valid = ($urandom_range(0, 3) == 0);
            end
            m_ready = ($urandom_range(0, 2) != 0);
            if (m_valid && m_ready && res_q.size() != 0) begin
                $display("txn result data=%0h err=%0d", m_data, m_err);
                void'(res_q.pop_front());
            end
            s_valid = (t < 600) && ($urandom_range(0, 1) == 1);
            s_cmd = 8'($urandom_range(0, 255)); s_in1 = $urandom; s_in2 = $urandom;
            if (s_valid && s_ready) exp_q.push_back({s_cmd, s_in1, s_in2});
            tick();
        end
        s_valid = 1'b0; eng_valid = 1'b0; m_ready = 1'b0;
        chk("rnd_drained", 80'(busy), 80'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
